// File: rtl/crc_frame_sequencer.sv
// Frame sequencer for a shared CRC/output engine.
// Round-robin grant, per-word FSM, watchdog and length check.
module crc_frame_sequencer #(
  parameter int NBR_STATES  = 2,
  parameter int NREQ        = 2,
  parameter int FRAME_WORDS = 14,
  parameter int SEND_CYCLES = 45,
  parameter int TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  output logic [NREQ-1:0]           grant,
  output logic [$clog2(NREQ)-1:0]   chan_sel,
  output logic                      busy,
  output logic                      done,
  output logic                      err_timeout,
  output logic                      err_len,
  output logic [NBR_STATES:0]       state_reg,
  input  logic                      tick_CRC,
  input  logic                      tick_WRITE,
  input  logic                      tick_NEXT,
  input  logic                      tick_IDLE
);

  localparam int SW  = NBR_STATES + 1;
  localparam int CW  = $clog2(NREQ);
  localparam int WCW = $clog2(FRAME_WORDS);
  localparam int SCW = $clog2(SEND_CYCLES);
  localparam int WDW = $clog2(TIMEOUT);

  localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);
  localparam logic [SCW-1:0] LAST_SEND = SCW'(SEND_CYCLES - 1);
  localparam logic [WDW-1:0] LAST_WAIT = WDW'(TIMEOUT - 1);

  typedef enum logic [SW-1:0] {
    S_IDLE  = SW'(0),
    S_FETCH = SW'(1),
    S_CRC   = SW'(2),
    S_WRITE = SW'(3),
    S_SEND  = SW'(4)
  } state_t;

  state_t          state;
  logic [CW-1:0]   ptr;
  logic [WCW-1:0]  word_cnt;
  logic [SCW-1:0]  send_cnt;
  logic [WDW-1:0]  wdog;
  logic            settled;

  logic            win_found;
  logic [CW-1:0]   win_idx;
  logic [CW-1:0]   ptr_nxt;
  int              cand;

  logic            q_crc;
  logic            q_write;
  logic            q_next;
  logic            q_idle;
  logic            adv;
  logic            wd_hit;

  assign state_reg = state;

  // Ticks are stale on the first cycle of a state; only trust them once settled.
  assign q_crc   = settled & tick_CRC;
  assign q_write = settled & tick_WRITE;
  assign q_next  = settled & tick_NEXT;
  assign q_idle  = settled & tick_IDLE;
  assign wd_hit  = (wdog == LAST_WAIT);

  // Round-robin pick: first requester at or after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req[CW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = CW'(cand);
      end
    end
  end

  assign ptr_nxt = (win_idx == CW'(NREQ - 1)) ? '0
                                               : win_idx + CW'(1);

  // Qualified advance condition for the three engine-wait states.
  always_comb begin
    adv = 1'b0;
    unique case (1'b1)
      (state == S_FETCH): adv = q_crc;
      (state == S_CRC):   adv = q_write;
      (state == S_WRITE): adv = q_next | q_idle;
      default:            adv = 1'b0;
    endcase
  end

  // Main sequencer: arbitration, per-word loop, send phase, watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= '0;
      chan_sel    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
      ptr         <= '0;
      word_cnt    <= '0;
      wdog        <= '0;
      send_cnt    <= '0;
      settled     <= 1'b0;
    end else begin
      done    <= 1'b0;
      settled <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (win_found) begin
            state    <= S_FETCH;
            busy     <= 1'b1;
            grant    <= NREQ'(1) << win_idx;
            chan_sel <= win_idx;
            ptr      <= ptr_nxt;
            word_cnt <= '0;
            wdog     <= '0;
            settled  <= 1'b0;
          end
        end
        S_FETCH, S_CRC, S_WRITE: begin
          if (adv) begin
            wdog    <= '0;
            settled <= 1'b0;
            if (state == S_FETCH) begin
              state <= S_CRC;
            end else if (state == S_CRC) begin
              state <= S_WRITE;
            end else if (q_idle) begin
              state    <= S_SEND;
              send_cnt <= '0;
              if (word_cnt != LAST_WORD) err_len <= 1'b1;
            end else if (word_cnt == LAST_WORD) begin
              state    <= S_SEND;
              send_cnt <= '0;
              err_len  <= 1'b1;
            end else begin
              state    <= S_FETCH;
              word_cnt <= word_cnt + 1'b1;
            end
          end else if (wd_hit) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            grant       <= '0;
            err_timeout <= 1'b1;
            wdog        <= '0;
            settled     <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_SEND: begin
          if (send_cnt == LAST_SEND) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            grant   <= '0;
            done    <= 1'b1;
            settled <= 1'b0;
          end else begin
            send_cnt <= send_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_sequencer.sv
// Bench for crc_frame_sequencer: engine model, vector table,
// frame scoreboard and hand-driven settle/reset sequence.
module tb_crc_frame_sequencer;

  localparam int M_NORMAL  = 0;
  localparam int M_NOWRITE = 1;
  localparam int M_MANUAL  = 2;

  typedef struct {
    bit         rst_before;
    logic [1:0] req;
    int         mode;
    int         words;
    logic [1:0] e_grant;
    int         e_chan;
    bit         e_done;
    bit         e_len;
    bit         e_to;
    int         e_fetch;
    int         e_dwell;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = '0;
  logic [1:0] grant;
  logic [0:0] chan_sel;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic       err_len;
  logic [2:0] state_reg;
  logic       tick_CRC = 1'b0;
  logic       tick_WRITE = 1'b0;
  logic       tick_NEXT = 1'b0;
  logic       tick_IDLE = 1'b0;

  crc_frame_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .chan_sel    (chan_sel),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .err_len     (err_len),
    .state_reg   (state_reg),
    .tick_CRC    (tick_CRC),
    .tick_WRITE  (tick_WRITE),
    .tick_NEXT   (tick_NEXT),
    .tick_IDLE   (tick_IDLE)
  );

  always #5 clk = ~clk;

  vec_t       sb[$];
  vec_t       vecs[8];
  int         checks = 0;
  int         errors = 0;
  int         mode = M_NORMAL;
  int         target = 14;
  bit         sb_on = 1'b0;
  bit         prev_busy = 1'b0;
  logic [1:0] prev_grant = '0;
  logic [2:0] prev_state = '0;
  int         dwell = 0;
  int         prev_dwell = 0;
  int         fetch_cnt = 0;
  logic [1:0] cap_grant = '0;
  logic       cap_chan = 1'b0;
  logic [2:0] eng_prev = '0;
  int         eng_cnt = 0;
  int         eng_fetch = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Engine model: tick the current state 3 cycles after entering it.
  task automatic engine_step();
    if (state_reg != eng_prev) begin
      if (state_reg == 3'd1)
        eng_fetch = (eng_prev == 3'd0) ? 1 : eng_fetch + 1;
      eng_prev = state_reg;
      eng_cnt  = 0;
    end else begin
      eng_cnt++;
    end
    if (mode == M_MANUAL) return;
    tick_CRC   = 1'b0;
    tick_WRITE = 1'b0;
    tick_NEXT  = 1'b0;
    tick_IDLE  = 1'b0;
    if (eng_cnt >= 2) begin
      case (state_reg)
        3'd1: tick_CRC = 1'b1;
        3'd2: if (mode != M_NOWRITE) tick_WRITE = 1'b1;
        3'd3: begin
          if (eng_fetch == target) tick_IDLE = 1'b1;
          else                     tick_NEXT = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic score_frame();
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected_frame_end");
      return;
    end
    e = sb.pop_front();
    chk("grant", 32'(cap_grant), 32'(e.e_grant));
    chk("chan_sel", 32'(cap_chan), e.e_chan);
    chk("done_at_end", 32'(done), 32'(e.e_done));
    chk("err_len", 32'(err_len), 32'(e.e_len));
    chk("err_timeout", 32'(err_timeout), 32'(e.e_to));
    chk("fetch_loops", fetch_cnt, e.e_fetch);
    chk("last_dwell", prev_dwell, e.e_dwell);
    chk("grant_cleared", 32'(grant), 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (state_reg == prev_state) begin
      dwell++;
    end else begin
      prev_dwell = dwell;
      dwell      = 1;
    end
    if (busy && !prev_busy) begin
      fetch_cnt = 0;
      cap_grant = grant;
      cap_chan  = chan_sel[0];
    end
    if (state_reg != prev_state && state_reg == 3'd1) fetch_cnt++;
    chk("grant_onehot", 32'($countones(grant) <= 1), 1);
    if (busy && prev_busy)
      chk("grant_hold", 32'(grant), 32'(prev_grant));
    if (!busy && prev_busy && sb_on) score_frame();
    engine_step();
    prev_busy  = busy;
    prev_grant = grant;
    prev_state = state_reg;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    int k = 0;
    while (sb.size() != 0 && k < n) begin
      cycle();
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.rst_before) do_reset();
    mode   = v.mode;
    target = v.words;
    sb.push_back(v);
    req = v.req;
    for (int k = 0; k < 5 && !busy; k++) cycle();
    req = '0;
    wait_drain(4000);
    cycle();
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after", 32'(busy), 0);
  endtask

  initial begin
    vec_t a;
    vecs[0] = '{1'b0, 2'b01, M_NORMAL,  14, 2'b01, 0,
                1'b1, 1'b0, 1'b0, 14, 45};
    vecs[1] = '{1'b0, 2'b10, M_NORMAL,  14, 2'b10, 1,
                1'b1, 1'b0, 1'b0, 14, 45};
    vecs[2] = '{1'b0, 2'b11, M_NORMAL,  14, 2'b01, 0,
                1'b1, 1'b0, 1'b0, 14, 45};
    vecs[3] = '{1'b0, 2'b11, M_NORMAL,  14, 2'b10, 1,
                1'b1, 1'b0, 1'b0, 14, 45};
    vecs[4] = '{1'b0, 2'b10, M_NOWRITE, 14, 2'b10, 1,
                1'b0, 1'b0, 1'b1, 1, 255};
    vecs[5] = '{1'b0, 2'b01, M_NORMAL,  14, 2'b01, 0,
                1'b1, 1'b0, 1'b1, 14, 45};
    vecs[6] = '{1'b0, 2'b11, M_NORMAL,  10, 2'b10, 1,
                1'b1, 1'b1, 1'b1, 10, 45};
    vecs[7] = '{1'b1, 2'b01, M_NORMAL,  15, 2'b01, 0,
                1'b1, 1'b1, 1'b0, 14, 45};

    do_reset();
    chk("rst_state", 32'(state_reg), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_chan", 32'(chan_sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err_to", 32'(err_timeout), 0);
    chk("rst_err_len", 32'(err_len), 0);

    sb_on  = 1'b1;
    mode   = M_NORMAL;
    target = 14;
    a = '{1'b0, 2'b11, M_NORMAL, 14, 2'b01, 0,
          1'b1, 1'b0, 1'b0, 14, 45};
    sb.push_back(a);
    a.e_grant = 2'b10;
    a.e_chan  = 1;
    sb.push_back(a);
    a.e_grant = 2'b01;
    a.e_chan  = 0;
    sb.push_back(a);
    req = 2'b11;
    wait_drain(6000);
    req = '0;
    cycle();
    chk("alt_done_one_cycle", 32'(done), 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    sb_on = 1'b0;
    do_reset();
    chk("rst_clears_err_len", 32'(err_len), 0);
    mode       = M_MANUAL;
    tick_CRC   = 1'b0;
    tick_WRITE = 1'b0;
    tick_NEXT  = 1'b0;
    tick_IDLE  = 1'b0;
    req = 2'b01;
    cycle();
    chk("enter_fetch", 32'(state_reg), 1);
    req       = '0;
    tick_CRC  = 1'b1;
    tick_NEXT = 1'b1;
    cycle();
    chk("stale_fetch_ignored", 32'(state_reg), 1);
    tick_NEXT = 1'b0;
    cycle();
    chk("settled_to_crc", 32'(state_reg), 2);
    tick_CRC   = 1'b0;
    tick_WRITE = 1'b1;
    cycle();
    chk("stale_crc_ignored", 32'(state_reg), 2);
    tick_WRITE = 1'b0;
    rst = 1'b1;
    cycle();
    chk("midrst_state", 32'(state_reg), 0);
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_chan", 32'(chan_sel), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_err_to", 32'(err_timeout), 0);
    chk("midrst_err_len", 32'(err_len), 0);
    rst = 1'b0;
    cycle();
    chk("post_rst_idle", 32'(state_reg), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
